ws_row_ctrl: RTL

Sequencer for one weight-stationary PE row (ROW PEs sharing one fmap chain and a common Op_sel). It gathers ROW kernel words from a serial valid/ready source, latches them into the row with a one-cycle weight-load strobe, and streams a programmed number of fmap words into the chain. It then drains the pipeline, flagging which PE's Result_out carries a valid product on each cycle. It sits between the array-level scheduler (start/done) and the WS_PE_row datapath.

---
 rtl/ws_ctrl_pkg.sv | 32 +++
 rtl/ws_row_ctrl_if.sv | 23 ++
 rtl/ws_valid_pipe.sv | 37 +++
 rtl/ws_row_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ws_ctrl_pkg.sv
// Shared types and sizing for the weight-stationary row controller.
// Row geometry lives here so the controller, interface and bench agree.
package ws_ctrl_pkg;

    localparam int IN_WORD_SIZE = 16;
    localparam int ROW          = 3;
    localparam int MAX_LEN      = 256;
    localparam int PE_LAT       = 1;

    // Counter width that stays legal (>= 1 bit) for degenerate counts.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int LEN_W     = $clog2(MAX_LEN + 1);
    localparam int KCNT_W    = cnt_w(ROW);
    localparam int DRAIN_CYC = ROW - 1 + PE_LAT;
    localparam int DCNT_W    = cnt_w(DRAIN_CYC);

    typedef logic [IN_WORD_SIZE-1:0] word_t;
    typedef logic [LEN_W-1:0]        len_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LATCH  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/ws_row_ctrl_if.sv
// Kernel and fmap word sources feeding the row controller.
// A word moves on a rising edge where valid and ready are both high; valid must not depend on ready.
interface ws_row_ctrl_if;
    import ws_ctrl_pkg::*;

    logic  k_valid;
    logic  k_ready;
    word_t k_data;
    logic  f_valid;
    logic  f_ready;
    word_t f_data;

    modport master (
        output k_valid, k_data, f_valid, f_data,
        input  k_ready, f_ready
    );

    modport slave (
        input  k_valid, k_data, f_valid, f_data,
        output k_ready, f_ready
    );

endinterface

// File: rtl/ws_valid_pipe.sv
// Tag delay line for the PE row: res_valid[i] is the accepted-word tag delayed i+PE_LAT cycles.
module ws_valid_pipe #(
    parameter int ROW    = 3,
    parameter int PE_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tag_in,
    output logic [ROW-1:0] res_valid
);

    localparam int DEPTH = ROW - 1 + PE_LAT;
    localparam int SH_W  = (DEPTH > 0) ? DEPTH : 1;

    logic [SH_W-1:0] sh_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q <= '0;
        end else begin
            sh_q[0] <= tag_in;
            for (int i = 1; i < SH_W; i++) begin
                sh_q[i] <= sh_q[i-1];
            end
        end
    end

    // Stage k of the line holds the tag from k+1 cycles ago.
    for (genvar i = 0; i < ROW; i++) begin : g_tap
        if (i + PE_LAT == 0) begin : g_direct
            assign res_valid[i] = tag_in;
        end else begin : g_reg
            assign res_valid[i] = sh_q[i + PE_LAT - 1];
        end
    end

endmodule

// File: rtl/ws_row_ctrl.sv
// Pass sequencer for one weight-stationary PE row: load kernels, latch, stream fmap, drain.
// Optional build macro WS_CTRL_KERNEL_REUSE_EN adds reuse_kernel to skip load/latch.
module ws_row_ctrl
    import ws_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  len_t                fmap_len,
`ifdef WS_CTRL_KERNEL_REUSE_EN
    input  logic                reuse_kernel,
`endif
    output logic                busy,
    output logic                done,
    ws_row_ctrl_if.slave        src,
    output word_t [ROW-1:0]     kernel_out,
    output logic                op_sel,
    output word_t               fmap_out,
    output logic [ROW-1:0]      res_valid,
    output state_t              state_dbg
);

    state_t              state_q;
    state_t              state_d;
    logic [KCNT_W-1:0]   kcnt_q;
    len_t                fcnt_q;
    logic [DCNT_W-1:0]   dcnt_q;
    len_t                len_q;
    word_t [ROW-1:0]     kernel_q;
    word_t               fmap_q;

    logic start_ok;
    logic k_fire;
    logic f_fire;
    logic last_word;
    logic reuse;

`ifdef WS_CTRL_KERNEL_REUSE_EN
    assign reuse = reuse_kernel;
`else
    assign reuse = 1'b0;
`endif

    assign start_ok  = (state_q == S_IDLE) && start;
    assign k_fire    = (state_q == S_LOAD) && src.k_valid;
    assign f_fire    = (state_q == S_STREAM) && src.f_valid;
    assign last_word = ((fcnt_q + len_t'(1)) == len_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reuse) begin
                        state_d = (fmap_len == '0) ? S_DONE : S_STREAM;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (k_fire && (kcnt_q == KCNT_W'(ROW - 1))) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = (len_q == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                if (f_fire && last_word) begin
                    state_d = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DCNT_W'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Everything below is a decode of registered state or a register itself.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        op_sel      = 1'b0;
        src.k_ready = 1'b0;
        src.f_ready = 1'b0;
        unique case (state_q)
            S_LOAD:   begin busy = 1'b1; src.k_ready = 1'b1; end
            S_LATCH:  begin busy = 1'b1; op_sel = 1'b1; end
            S_STREAM: begin busy = 1'b1; src.f_ready = 1'b1; end
            S_DRAIN:  begin busy = 1'b1; end
            S_DONE:   begin done = 1'b1; end
            default:  begin end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kcnt_q   <= '0;
            fcnt_q   <= '0;
            dcnt_q   <= '0;
            len_q    <= '0;
            kernel_q <= '0;
            fmap_q   <= '0;
        end else begin
            if (start_ok) begin
                len_q <= fmap_len;
            end

            if (k_fire) begin
                kernel_q[kcnt_q] <= src.k_data;
                kcnt_q <= (kcnt_q == KCNT_W'(ROW - 1)) ? '0 : kcnt_q + KCNT_W'(1);
            end

            // Bubbles and non-stream cycles present a zero word to the chain.
            fmap_q <= f_fire ? src.f_data : '0;

            if (start_ok) begin
                fcnt_q <= '0;
            end else if (f_fire) begin
                fcnt_q <= fcnt_q + len_t'(1);
            end

            if (state_q == S_DRAIN) begin
                dcnt_q <= dcnt_q + DCNT_W'(1);
            end else begin
                dcnt_q <= '0;
            end
        end
    end

    ws_valid_pipe #(
        .ROW    (ROW),
        .PE_LAT (PE_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .tag_in    (f_fire),
        .res_valid (res_valid)
    );

    assign kernel_out = kernel_q;
    assign fmap_out   = fmap_q;
    assign state_dbg  = state_q;

endmodule
